// File: rtl/c17_test_sequencer.sv
// c17_test_sequencer: applies counter/LFSR patterns to a c17 DUT and scores
// its response against a built-in golden c17. Define MISR_EN for the signature MISR.
module c17_test_sequencer #(
  parameter int PAT_W = 5,
  parameter int OUT_W = 2,
  parameter int CNT_W = 16,
  parameter int SETTLE = 2,
  parameter logic [PAT_W-1:0] LFSR_SEED = 5'h1F
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [CNT_W-1:0] num_pat,
  output logic [PAT_W-1:0] dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_fail_vld,
  output logic [PAT_W-1:0] first_fail_pat,
  output logic [15:0]      signature
);

  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [PAT_W-1:0] SEED =
    (LFSR_SEED == '0) ? PAT_W'(1) : LFSR_SEED;

  typedef enum logic [2:0] {
    st_idle,
    st_drive,
    st_wait,
    st_sample,
    st_done
  } state_t;

  state_t state_q, state_d;

  logic             mode_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_nxt;
  logic [SW-1:0]    cnt_q;

  logic clear, accept, smp, adv;
  logic cnt_ld, cnt_dec;
  logic last, miss;

  logic n10, n11, n16, n19;
  logic [OUT_W-1:0] gold;
  logic [PAT_W-1:0] lfsr_nxt;

  // golden c17 on {N1,N2,N3,N6,N7}
  assign n10  = ~(dut_in[4] & dut_in[2]);
  assign n11  = ~(dut_in[2] & dut_in[1]);
  assign n16  = ~(dut_in[3] & n11);
  assign n19  = ~(n11 & dut_in[0]);
  assign gold = {~(n10 & n16), ~(n16 & n19)};

  assign miss     = (dut_out != gold);
  assign idx_nxt  = idx_q + CNT_W'(1);
  assign lfsr_nxt = {dut_in[3:0], dut_in[4] ^ dut_in[2]};
  assign last     = (idx_q == num_q - CNT_W'(1));

  assign busy = (state_q != st_idle);
  assign done = (state_q == st_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= st_idle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    accept  = 1'b0;
    smp     = 1'b0;
    adv     = 1'b0;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    unique case (state_q)
      st_idle: begin
        if (start) begin
          clear = 1'b1;
          if (num_pat != '0) begin
            accept  = 1'b1;
            state_d = st_drive;
          end else begin
            state_d = st_done;
          end
        end
      end
      st_drive: begin
        cnt_ld  = 1'b1;
        state_d = (SETTLE > 0) ? st_wait : st_sample;
      end
      st_wait: begin
        cnt_dec = 1'b1;
        if (cnt_q <= SW'(1)) state_d = st_sample;
      end
      st_sample: begin
        smp = 1'b1;
        if (last) begin
          state_d = st_done;
        end else begin
          adv     = 1'b1;
          state_d = st_drive;
        end
      end
      st_done: state_d = st_idle;
      default: state_d = st_idle;
    endcase
    // abort wins and must leave results untouched
    if (abort && state_q != st_idle) begin
      state_d = st_idle;
      smp     = 1'b0;
      adv     = 1'b0;
      cnt_ld  = 1'b0;
      cnt_dec = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in         <= '0;
      mode_q         <= 1'b0;
      num_q          <= '0;
      idx_q          <= '0;
      cnt_q          <= '0;
      mismatch_cnt   <= '0;
      first_fail_vld <= 1'b0;
      first_fail_pat <= '0;
    end else begin
      if (cnt_ld)       cnt_q <= SW'(SETTLE);
      else if (cnt_dec) cnt_q <= cnt_q - SW'(1);
      if (clear) begin
        mismatch_cnt   <= '0;
        first_fail_vld <= 1'b0;
        first_fail_pat <= '0;
      end
      if (accept) begin
        mode_q <= mode;
        num_q  <= num_pat;
        idx_q  <= '0;
        dut_in <= mode ? SEED : '0;
      end
      if (smp && miss) begin
        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (!first_fail_vld) begin
          first_fail_vld <= 1'b1;
          first_fail_pat <= dut_in;
        end
      end
      if (adv) begin
        idx_q  <= idx_nxt;
        dut_in <= mode_q ? lfsr_nxt : idx_nxt[PAT_W-1:0];
      end
    end
  end

`ifdef MISR_EN
  logic [15:0] sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sig_q <= 16'hFFFF;
    else if (clear) sig_q <= 16'hFFFF;
    else if (smp)
      sig_q <= {sig_q[14:0], 1'b0}
             ^ (sig_q[15] ? 16'h1021 : 16'h0000)
             ^ {{(16-OUT_W){1'b0}}, dut_out};
  end

  assign signature = sig_q;
`else
  assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_c17_test_sequencer.sv
// tb_c17_test_sequencer: random runs against golden, trojan and random-fault
// c17 models, scored by a pattern-list reference model.
module tb_c17_test_sequencer;

  localparam int S = 2;
  localparam int PER = S + 2;
`ifdef MISR_EN
  localparam logic MISR = 1'b1;
`else
  localparam logic MISR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] num_pat = '0;
  logic [4:0]  dut_in;
  logic [1:0]  dut_out;
  logic        busy, done, ffv;
  logic [15:0] mcnt, sig;
  logic [4:0]  ffp;

  int checks = 0;
  int errors = 0;
  int kind = 0;
  logic [1:0] ftab [32];
  bit seen [32];

  c17_test_sequencer #(.SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mode(mode), .num_pat(num_pat), .dut_in(dut_in),
    .dut_out(dut_out), .busy(busy), .done(done),
    .mismatch_cnt(mcnt), .first_fail_vld(ffv),
    .first_fail_pat(ffp), .signature(sig)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] gold(input logic [4:0] p);
    logic a1, a2, a3, a6, a7, g10, g11, g16, g19;
    {a1, a2, a3, a6, a7} = p;
    g10 = ~(a1 & a3);
    g11 = ~(a3 & a6);
    g16 = ~(a2 & g11);
    g19 = ~(g11 & a7);
    return {~(g10 & g16), ~(g16 & g19)};
  endfunction

  // DUT under test: 0 golden, 1 trojan (N23 = ~N16), 2 random faults
  function automatic logic [1:0] resp(input logic [4:0] p, input int k);
    logic [1:0] g;
    logic g16;
    g = gold(p);
    g16 = ~(p[3] & ~(p[2] & p[1]));
    if (k == 1) return {g[1], ~g16};
    if (k == 2) return g ^ ftab[p];
    return g;
  endfunction

  assign dut_out = resp(dut_in, kind);

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [1:0] r);
    int v;
    v = (int'(s) * 2) % 65536;
    if (s >= 16'h8000) v = v ^ 'h1021;
    return 16'(v ^ int'(r));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int em, input logic efv,
                         input logic [4:0] efp, input logic [15:0] es);
    chk({tag, "_cnt"}, mcnt, em);
    chk({tag, "_ffv"}, ffv, efv);
    chk({tag, "_ffp"}, ffp, efp);
    chk({tag, "_sig"}, sig, MISR ? es : 16'h0);
  endtask

  task automatic run(input logic m, input int n, input int k,
                     input int ab, input bit noise);
    logic [4:0] pats [$];
    int p, c, nsmp, viol, em, lim;
    logic efv;
    logic [4:0] efp;
    logic [15:0] es;
    logic [1:0] r;
    bit fin, aborted;
    kind = k;
    p = m ? 31 : 0;
    for (int i = 0; i < n; i++) begin
      pats.push_back(m ? 5'(p) : 5'(i % 32));
      p = ((p * 2) % 32) | (((p / 16) ^ (p / 4)) & 1);
    end
    foreach (seen[j]) seen[j] = 1'b0;
    @(posedge clk); #1;
    mode = m;
    num_pat = 16'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1; viol = 0; fin = 0; aborted = 0;
    lim = n * PER + 8;
    while (c <= lim) begin
      if (done) begin
        fin = 1;
        break;
      end
      if (c == ab) begin
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        aborted = 1;
        break;
      end
      if ((c - 1) / PER < n) begin
        if (dut_in !== pats[(c - 1) / PER]) viol++;
        if ((c - 1) % PER == S + 1) seen[dut_in] = 1'b1;
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        num_pat = 16'($urandom);
        mode = 1'($urandom);
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    nsmp = 0;
    for (int i = 0; i < n; i++)
      if (!aborted || (i + 1) * PER < ab) nsmp++;
    em = 0; efv = 0; efp = '0; es = 16'hFFFF;
    for (int i = 0; i < nsmp; i++) begin
      r = resp(pats[i], k);
      es = misr(es, r);
      if (r != gold(pats[i])) begin
        em++;
        if (!efv) begin
          efv = 1'b1;
          efp = pats[i];
        end
      end
    end
    chk("hold", viol, 0);
    if (aborted) begin
      chk("ab_busy", busy, 0);
      chk("ab_done", done, 0);
      chk_res("ab", em, efv, efp, es);
      repeat (3) begin
        @(posedge clk); #1;
        chk("ab_nodone", done, 0);
      end
      chk_res("ab_frz", em, efv, efp, es);
      chk("ab_din", dut_in, pats[(ab - 1) / PER]);
    end else begin
      chk("done_seen", fin, 1);
      chk("latency", c, n * PER + 1);
      chk_res("run", em, efv, efp, es);
      if (n > 0) chk("last_pat", dut_in, pats[n - 1]);
      @(posedge clk); #1;
      chk("done_pulse", done, 0);
      chk("idle", busy, 0);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_din"}, dut_in, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk_res(tag, 0, 1'b0, 5'h0, 16'hFFFF);
  endtask

  logic [15:0] sg, st;
  int cnt;

  initial begin
    foreach (ftab[j]) ftab[j] = 2'b00;
    #12;
    chk_reset("rst");
    rst_n = 1'b1;

    run(1'b0, 32, 0, -1, 1'b0);
    sg = sig;
    run(1'b0, 32, 1, -1, 1'b0);
    st = sig;
    chk("troj_cnt", mcnt, 6);
    chk("troj_ffp", ffp, 5'h01);
    chk("troj_ffv", ffv, 1);
    chk("sig_diff", (sg != st), MISR);

    run(1'b1, 31, 0, -1, 1'b0);
    cnt = 0;
    for (int j = 1; j < 32; j++) if (seen[j]) cnt++;
    chk("lfsr_all", cnt, 31);
    chk("lfsr_zero", seen[0], 0);

    run(1'b0, 32, 1, 1 + 2 * PER + 1, 1'b0);
    run(1'b0, 32, 1, -1, 1'b0);
    run(1'b0, 0, 0, -1, 1'b0);
    run(1'b1, 20, 1, -1, 1'b1);

    for (int t = 0; t < 8; t++) begin
      foreach (ftab[j]) ftab[j] = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      run(1'($urandom), $urandom_range(1, 45), $urandom_range(0, 2),
          ($urandom_range(0, 3) == 0) ? $urandom_range(2, 12) : -1,
          1'($urandom));
    end

    kind = 1;
    @(posedge clk); #1;
    mode = 1'b0;
    num_pat = 16'd32;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    #7 rst_n = 1'b1;
    run(1'b0, 10, 1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
